// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types for the pipeline hazard controller
package hazard_pkg;

    // Encoding matches the operand mux3x1 input order in the execute stage.
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_M  = 2'b01,
        FWD_W  = 2'b10
    } fwd_sel_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_e;

endpackage

// File: rtl/hazard_sat_cnt.sv
// rtl/hazard_sat_cnt.sv - saturating event counter with synchronous clear
module hazard_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear has priority; increment holds at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl_mc.sv
// rtl/hazard_ctrl_mc.sv - forwarding, stall/flush and multi-cycle execute hazard control
import hazard_pkg::*;

module hazard_ctrl_mc #(
    parameter int NREGS      = 32,
    parameter int NSRC       = 2,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 16,
    localparam int REG_W     = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NSRC*REG_W-1:0]   rsD,
    input  logic [NSRC*REG_W-1:0]   rsE,
    input  logic [REG_W-1:0]        rdE,
    input  logic [REG_W-1:0]        rdM,
    input  logic [REG_W-1:0]        rdW,
    input  logic                    RegWriteM,
    input  logic                    RegWriteW,
    input  logic                    is_loadE,
    input  logic                    PCSrcE,
    input  logic                    mc_validE,
    input  logic                    mc_done,
    input  logic                    cnt_clr,
    output logic [NSRC*2-1:0]       ForwardE,
    output logic                    StallF,
    output logic                    StallD,
    output logic                    StallE,
    output logic                    FlushD,
    output logic                    FlushE,
    output logic                    FlushM,
    output logic                    mc_start,
    output logic                    mc_timeout,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        flush_cnt
);

    localparam int WD_W = $clog2(MC_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_TIMEOUT - 1);

    mc_state_e        state_q, state_d;
    logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic             mc_timeout_q, mc_timeout_d;

    logic             lw_hit;
    logic             lw_stall;
    logic             busy;

    // Per-operand forward selection.
    for (genvar i = 0; i < NSRC; i++) begin : g_fwd
        logic [REG_W-1:0] rs;
        fwd_sel_e         sel;

        assign rs = rsE[i*REG_W +: REG_W];

        // The younger producer in M beats W; reads of x0 are never forwarded.
        always_comb begin
            sel = FWD_RF;
            if (rs != '0) begin
                if (RegWriteM && (rdM == rs)) begin
                    sel = FWD_M;
                end else if (RegWriteW && (rdW == rs)) begin
                    sel = FWD_W;
                end
            end
        end

        assign ForwardE[i*2 +: 2] = sel;
    end

    // Any decode source matching the load destination in execute.
    always_comb begin
        lw_hit = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (rsD[i*REG_W +: REG_W] == rdE) begin
                lw_hit = 1'b1;
            end
        end
    end

    assign lw_stall = is_loadE & (rdE != '0) & lw_hit;

    // A zero-latency op (done in its first E cycle) never enters BUSY nor freezes the pipe.
    assign busy = ((state_q == BUSY) & ~mc_done) |
                  ((state_q == IDLE) & mc_validE & ~mc_done);

    // Multi-cycle handshake FSM with watchdog; launch pulse is issued on the IDLE->BUSY edge.
    always_comb begin
        state_d      = state_q;
        wd_cnt_d     = wd_cnt_q;
        mc_timeout_d = mc_timeout_q;
        mc_start     = 1'b0;
        case (state_q)
            IDLE: begin
                if (mc_validE && !mc_done) begin
                    state_d  = BUSY;
                    wd_cnt_d = '0;
                    mc_start = 1'b1;
                end
            end
            BUSY: begin
                wd_cnt_d = wd_cnt_q + WD_W'(1);
                if (mc_done) begin
                    state_d = IDLE;
                end else if (wd_cnt_q == WD_LAST) begin
                    state_d      = IDLE;
                    mc_timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, watchdog and sticky timeout registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wd_cnt_q     <= '0;
            mc_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wd_cnt_q     <= wd_cnt_d;
            mc_timeout_q <= mc_timeout_d;
        end
    end

    assign mc_timeout = mc_timeout_q;

    // A frozen execute stage must not be flushed underneath the multi-cycle op.
    assign StallF = lw_stall | busy;
    assign StallD = lw_stall | busy;
    assign StallE = busy;
    assign FlushM = busy;
    assign FlushE = (lw_stall | PCSrcE) & ~busy;
    assign FlushD = PCSrcE & ~busy;

    hazard_sat_cnt #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (StallD),
        .cnt   (stall_cnt)
    );

    hazard_sat_cnt #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (FlushE),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// tb/tb_hazard_ctrl_mc.sv - directed self-checking bench for hazard_ctrl_mc
module tb_hazard_ctrl_mc;

    localparam int NSRC  = 3;
    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NSRC*REG_W-1:0] rsD, rsE;
    logic [REG_W-1:0]      rdE, rdM, rdW;
    logic                  RegWriteM, RegWriteW, is_loadE, PCSrcE;
    logic                  mc_validE, mc_done, cnt_clr;
    logic [NSRC*2-1:0]     ForwardE;
    logic                  StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic                  mc_start, mc_timeout;
    logic [CNT_W-1:0]      stall_cnt, flush_cnt;

    int passed = 0;
    int total  = 0;

    hazard_ctrl_mc #(
        .NREGS      (32),
        .NSRC       (NSRC),
        .MC_TIMEOUT (64),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rsD        (rsD),
        .rsE        (rsE),
        .rdE        (rdE),
        .rdM        (rdM),
        .rdW        (rdW),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .is_loadE   (is_loadE),
        .PCSrcE     (PCSrcE),
        .mc_validE  (mc_validE),
        .mc_done    (mc_done),
        .cnt_clr    (cnt_clr),
        .ForwardE   (ForwardE),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushM     (FlushM),
        .mc_start   (mc_start),
        .mc_timeout (mc_timeout),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rsD = '0; rsE = '0; rdE = '0; rdM = '0; rdW = '0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; is_loadE = 1'b0; PCSrcE = 1'b0;
        mc_validE = 1'b0; mc_done = 1'b0; cnt_clr = 1'b0;
        #12;
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        check("rst_timeout", mc_timeout, 0);
        check("rst_mc_start", mc_start, 0);
        check("rst_stallf", StallF, 0);
        check("rst_fwd", ForwardE, 0);
        rst_n = 1'b1;
        tick();

        // Forwarding: rsE[0]=5, rsE[1]=0, rsE[2]=7
        RegWriteM = 1'b1; rdM = 5'd5; RegWriteW = 1'b1; rdW = 5'd5;
        rsE = {5'd7, 5'd0, 5'd5};
        #1 check("fwd_m_beats_w", ForwardE, 6'b00_00_01);
        rdM = 5'd3;
        #1 check("fwd_w", ForwardE, 6'b00_00_10);
        RegWriteW = 1'b0;
        #1 check("fwd_rf", ForwardE, 6'b00_00_00);
        RegWriteW = 1'b1; rdW = 5'd7;
        #1 check("fwd_w_op2", ForwardE, 6'b10_00_00);
        rdM = 5'd0; rdW = 5'd0;
        #1 check("fwd_x0_never", ForwardE, 6'b00_00_00);
        RegWriteM = 1'b0; RegWriteW = 1'b0; rsE = '0;
        tick();

        // Load-use
        is_loadE = 1'b1; rdE = 5'd4; rsD = {5'd0, 5'd4, 5'd0};
        #1;
        check("lu_stallf", StallF, 1);
        check("lu_stalld", StallD, 1);
        check("lu_flushe", FlushE, 1);
        check("lu_stalle", StallE, 0);
        check("lu_flushd", FlushD, 0);
        tick();
        rdE = 5'd0;
        #1;
        check("lu_rd0_stalld", StallD, 0);
        check("lu_rd0_flushe", FlushE, 0);
        check("lu_stall_cnt", stall_cnt, 1);
        check("lu_flush_cnt", flush_cnt, 1);
        is_loadE = 1'b0; rsD = '0;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_stall_cnt", stall_cnt, 0);
        check("clr_flush_cnt", flush_cnt, 0);

        // Multi-cycle op, done after 5 cycles
        mc_validE = 1'b1;
        #1;
        check("mc_start_c0", mc_start, 1);
        check("mc_stalle_c0", StallE, 1);
        check("mc_flushm_c0", FlushM, 1);
        check("mc_stallf_c0", StallF, 1);
        for (int k = 1; k < 5; k++) begin
            tick();
            check("mc_start_low", mc_start, 0);
            check("mc_stalle", StallE, 1);
            check("mc_flushm", FlushM, 1);
            check("mc_flushe_low", FlushE, 0);
        end
        tick();
        mc_done = 1'b1;
        #1;
        check("mc_done_stalle", StallE, 0);
        check("mc_done_flushm", FlushM, 0);
        check("mc_done_stalld", StallD, 0);
        tick();
        mc_validE = 1'b0; mc_done = 1'b0;
        #1;
        check("mc_stall_cnt", stall_cnt, 5);
        check("mc_flush_cnt", flush_cnt, 0);
        check("mc_idle_after", StallE, 0);

        // Zero-latency op and stray done
        mc_validE = 1'b1; mc_done = 1'b1;
        #1;
        check("lat0_start", mc_start, 0);
        check("lat0_stalle", StallE, 0);
        tick();
        mc_validE = 1'b0;
        #1 check("stray_done_stalle", StallE, 0);
        tick();
        mc_done = 1'b0;
        #1 check("lat0_idle", StallE, 0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;

        // Branch flush, then the same during BUSY
        PCSrcE = 1'b1;
        #1;
        check("br_flushd", FlushD, 1);
        check("br_flushe", FlushE, 1);
        tick();
        PCSrcE = 1'b0;
        #1 check("br_flush_cnt", flush_cnt, 1);
        mc_validE = 1'b1;
        tick();
        PCSrcE = 1'b1;
        #1;
        check("busy_br_flushd", FlushD, 0);
        check("busy_br_flushe", FlushE, 0);
        check("busy_br_stalle", StallE, 1);
        tick();
        PCSrcE = 1'b0; mc_done = 1'b1;
        #1 check("busy_br_release", StallE, 0);
        tick();
        mc_validE = 1'b0; mc_done = 1'b0;
        #1 check("busy_br_flush_cnt", flush_cnt, 1);

        // Watchdog timeout
        mc_validE = 1'b1;
        #1 check("wd_start", mc_start, 1);
        for (int k = 1; k <= 64; k++) begin
            tick();
        end
        check("wd_not_yet", mc_timeout, 0);
        check("wd_busy_c64", StallE, 1);
        tick();
        check("wd_timeout", mc_timeout, 1);
        check("wd_relaunch", mc_start, 1);
        check("wd_stall_sat", stall_cnt, 15);
        mc_validE = 1'b0;
        #1 check("wd_idle", StallE, 0);
        tick();
        check("wd_sticky", mc_timeout, 1);

        // Saturation with a held load-use stall, then clear beating increment
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        is_loadE = 1'b1; rdE = 5'd4; rsD = {5'd0, 5'd4, 5'd0};
        for (int k = 0; k < 20; k++) begin
            tick();
        end
        check("sat_stall_cnt", stall_cnt, 15);
        check("sat_flush_cnt", flush_cnt, 15);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_wins_stall", stall_cnt, 0);
        check("clr_wins_flush", flush_cnt, 0);
        check("clr_keeps_timeout", mc_timeout, 1);
        is_loadE = 1'b0; rsD = '0; rdE = '0;

        // Reset mid-BUSY
        mc_validE = 1'b1;
        tick();
        tick();
        mc_validE = 1'b0;
        #1 check("pre_rst_busy", StallE, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_stalle", StallE, 0);
        check("rst_mid_timeout", mc_timeout, 0);
        check("rst_mid_stall_cnt", stall_cnt, 0);
        check("rst_mid_flush_cnt", flush_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", StallE, 0);
        check("post_rst_start", mc_start, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_mc.md
# hazard_ctrl_mc

Parametrised successor to the 5-stage core's hazard unit, sitting beside the pipeline registers in the core top.
- Resolves RAW forwarding for NSRC source operands per instruction.
- Generates load-use stalls and branch flushes.
- Adds a multi-cycle execute handshake (mul/div) that freezes F/D/E and bubbles M until the unit completes, with a watchdog.
- Keeps saturating stall/flush performance counters.

## Interface
Parameters:
- NREGS, 32, architectural register count; REG_W = $clog2(NREGS)
- NSRC, 2, source operands per instruction (3 for R4-type fused ops)
- MC_TIMEOUT, 64, max BUSY cycles before watchdog abort (≥2)
- CNT_W, 16, perf counter width

Ports (clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low):
- clk  in  1  core clock
- rst_n  in  1  async active-low reset
- rsD  in  NSRC×REG_W  source regs in Decode
- rsE  in  NSRC×REG_W  source regs in Execute
- rdE, rdM, rdW  in  REG_W each  destination regs per stage
- RegWriteM, RegWriteW  in  1 each  write enables in M/W
- is_loadE  in  1  Execute holds a load
- PCSrcE  in  1  taken branch/jump resolved in Execute
- mc_validE  in  1  Execute holds a multi-cycle op
- mc_done  in  1  multi-cycle unit result valid (one-cycle pulse)
- cnt_clr  in  1  synchronous clear of perf counters
- ForwardE  out  NSRC×2  per-operand forward select
- StallF, StallD, StallE  out  1 each  hold stage register
- FlushD, FlushE, FlushM  out  1 each  bubble into stage register
- mc_start  out  1  one-cycle launch pulse to multi-cycle unit
- mc_timeout  out  1  sticky watchdog flag
- stall_cnt, flush_cnt  out  CNT_W each  saturating counters

## Operation
- Forwarding, per operand i, combinational:
  - M select (01) if RegWriteM & rdM==rsE[i] & rsE[i]!=0.
  - Else W select (10) if RegWriteW & rdW==rsE[i] & rsE[i]!=0.
  - Else RF (00).
  - M beats W; x0 is never forwarded.
- Load-use: lw_stall = is_loadE & rdE!=0 & any(rsD[i]==rdE).
- FSM states: IDLE, BUSY.
  - IDLE→BUSY: mc_validE & !mc_done; mc_start=1 for that cycle only.
  - BUSY→IDLE: on mc_done, or when wd_cnt==MC_TIMEOUT-1 (then set mc_timeout).
  - wd_cnt clears on entry to BUSY and increments each BUSY cycle.
- Stall/flush outputs:
  - busy = (state==BUSY & !mc_done) | (state==IDLE & mc_validE & !mc_done).
  - StallF = StallD = lw_stall | busy.
  - StallE = busy.
  - FlushM = busy.
  - FlushE = (lw_stall | PCSrcE) & !busy.
  - FlushD = PCSrcE & !busy.
- Perf counters:
  - stall_cnt +1 each cycle StallD=1; flush_cnt +1 each cycle FlushE=1.
  - Both saturate at all-ones.
  - cnt_clr wins over increment.

## Timing
- Forward selects, stalls and flushes are combinational in the same cycle; no added latency.
- A multi-cycle op with mc_done in the cycle it reaches E (latency 0) causes no stall and no mc_start.
- Otherwise the pipeline freezes from the first E cycle through the cycle before mc_done. In the mc_done cycle, stalls drop and E/M captures the result.
- mc_done in IDLE without mc_validE is ignored.
- mc_validE and PCSrcE never coincide. If they do, busy wins and flushes are suppressed.
- Reset values: state=IDLE, wd_cnt=0, mc_timeout=0, counters=0, mc_start=0. Combinational outputs follow inputs.
- Reset mid-BUSY returns to IDLE immediately.
- mc_timeout clears only on reset.

## Structure
- Shared package `hazard_pkg`:
  - fwd_sel_e: FWD_RF=2'b00, FWD_M=2'b01, FWD_W=2'b10, matching the existing mux3x1 input order.
  - mc_state_e: IDLE, BUSY.
- Sub-module `hazard_sat_cnt`, parameter W, with clk, rst_n, clr and inc ports. Instantiated twice.
- Forwarding compare is a generate loop over NSRC.

## Test plan
- NSRC=3: rdM=5, RegWriteM=1, rdW=5, RegWriteW=1, rsE={5,0,7} → ForwardE={01,00,00}. Then rdM=3 → ForwardE[0]=10.
- is_loadE=1, rdE=4, rsD[1]=4 → StallF=StallD=FlushE=1, StallE=0. With rdE=0 → no stall.
- mc_validE held, mc_done asserted after 5 cycles → mc_start pulse in cycle 0; StallE=FlushM=1 for 5 cycles; release in the done cycle; stall_cnt=5.
- mc_validE held, mc_done never → BUSY for 64 cycles, then IDLE with mc_timeout=1 sticky.
- PCSrcE pulse → FlushD=FlushE=1 for one cycle, flush_cnt +1. The same pulse during BUSY → flushes suppressed.
- CNT_W=4, stall held 20 cycles → stall_cnt=15. cnt_clr → 0 next cycle. rst_n low mid-BUSY → IDLE, all registers 0.
